pattern_merge_pipe: RTL and testbench

PATTERN_MERGE_PIPE -- requirements
Module: pattern_merge_pipe

---
 rtl/pattern_merge_pipe.sv | 107 ++++++++++
 tb/tb_pattern_merge_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_merge_pipe.sv
// NAND-fold lane merger feeding a valid/ready pipeline of rotate-NAND mixing stages.
// Optional out_parity output is enabled by defining PATTERN_MERGE_PARITY_EN.
module pattern_merge_pipe #(
  parameter int WIDTH  = 5,
  parameter int LANES  = 3,
  parameter int STAGES = 2
) (
  input  logic                   blif_clk_net,
  input  logic                   blif_reset_net,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_count
`ifdef PATTERN_MERGE_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

  function automatic logic [WIDTH-1:0] nand_fold(
    input logic [LANES*WIDTH-1:0] v
  );
    logic [WIDTH-1:0] m;
    m = v[WIDTH-1:0];
    for (int i = 1; i < LANES; i++)
      m = ~(m & v[i*WIDTH +: WIDTH]);
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] mix(
    input logic [WIDTH-1:0] d
  );
    return ~(d & {d[WIDTH-2:0], d[WIDTH-1]});
  endfunction

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] load;
  logic [7:0]        count_q;
  logic [7:0]        count_d;

  // Ready ripples back from the output: a stage loads if empty or drained.
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = ~valid_q[k] | acc;
      acc     = load[k];
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++)
      data_d[k] = data_q[k];
    if (load[0]) begin
      valid_d[0] = in_valid;
      data_d[0]  = nand_fold(in_data);
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = mix(data_q[k-1]);
      end
    end
  end

  assign count_d = count_q + {7'd0, valid_q[STAGES-1] & out_ready};

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < STAGES; k++)
        data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int k = 0; k < STAGES; k++)
        data_q[k] <= data_d[k];
    end
  end

`ifdef PATTERN_MERGE_PARITY_EN
  logic parity_q;

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net)
      parity_q <= 1'b0;
    else
      parity_q <= ^data_d[STAGES-1];
  end

  assign out_parity = parity_q;
`endif

  assign in_ready  = load[0];
  assign out_data  = data_q[STAGES-1];
  assign out_valid = valid_q[STAGES-1];
  assign out_count = count_q;

endmodule

// File: tb/tb_pattern_merge_pipe.sv
// Directed bench for pattern_merge_pipe (WIDTH=5, LANES=3, STAGES=2).
// Hand-computed vectors plus a scoreboarded random stream.
module tb_pattern_merge_pipe;

  localparam int W = 5;
  localparam int L = 3;
  localparam int S = 2;

  logic           clk;
  logic           rst_n;
  logic [L*W-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     out_count;
`ifdef PATTERN_MERGE_PARITY_EN
  logic           out_parity;
`endif

  int passed = 0;
  int total  = 0;

  pattern_merge_pipe #(
    .WIDTH (W),
    .LANES (L),
    .STAGES(S)
  ) dut (
    .blif_clk_net  (clk),
    .blif_reset_net(rst_n),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_count     (out_count)
`ifdef PATTERN_MERGE_PARITY_EN
    ,
    .out_parity    (out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lanes 0 and 1 zero: the fold then reduces to ~lane2.
  function automatic logic [L*W-1:0] vec(input logic [W-1:0] l2);
    return {l2, 5'b00000, 5'b00000};
  endfunction

  function automatic logic [W-1:0] model(input logic [L*W-1:0] v);
    logic [W-1:0] m;
    logic [W-1:0] r;
    m = v[4:0];
    m = ~(m & v[9:5]);
    m = ~(m & v[14:10]);
    r = (m << 1) | (m >> (W - 1));
    return ~(m & r);
  endfunction

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] exp_d;
    int bad;
    int acc_n;
    int cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;

    // Single transfer, latency and result
    out_ready = 1'b1;
    in_data   = vec(5'b10100);
    in_valid  = 1'b1;
    #1;
    chk("single_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("lat_early", 32'(out_valid), 32'd0);
    step();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'h1d);
`ifdef PATTERN_MERGE_PARITY_EN
    chk("lat_parity", 32'(out_parity), 32'd0);
`endif
    chk("cnt_before", 32'(out_count), 32'd0);
    step();
    chk("cnt_after", 32'(out_count), 32'd1);
    chk("single_gone", 32'(out_valid), 32'd0);

    // Back-pressure fill then ordered drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = vec(5'b10100);
    step();
    in_data = vec(5'b00001);
    #1;
    chk("fill_rdy", 32'(in_ready), 32'd1);
    step();
    chk("full_rdy", 32'(in_ready), 32'd0);
    chk("full_data", 32'(out_data), 32'h1d);
    in_data = vec(5'b11111);
    step();
    chk("stall_rdy", 32'(in_ready), 32'd0);
    chk("stall_data", 32'(out_data), 32'h1d);
    chk("stall_cnt", 32'(out_count), 32'd1);
    out_ready = 1'b1;
    #1;
    chk("comb_rdy", 32'(in_ready), 32'd1);
    step();
    in_data = vec(5'b01010);
    chk("drain2", 32'(out_data), 32'h03);
    step();
    in_valid = 1'b0;
    chk("drain3", 32'(out_data), 32'h1f);
    step();
    chk("drain4", 32'(out_data), 32'h1e);
    chk("drain4_v", 32'(out_valid), 32'd1);
    step();
    chk("drain_cnt", 32'(out_count), 32'd5);
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset with two entries in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = vec(5'b00001);
    step();
    step();
    in_valid = 1'b0;
    chk("pre_rst_v", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v", 32'(out_valid), 32'd0);
    chk("mid_rst_d", 32'(out_data), 32'd0);
    chk("mid_rst_c", 32'(out_count), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_v", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    step();
    chk("post_rst_v2", 32'(out_valid), 32'd0);
    chk("post_rst_c", 32'(out_count), 32'd0);

    // 256 streamed transfers wrap the counter
    in_data  = '0;
    in_valid = 1'b1;
    bad      = 0;
    #1;
    repeat (256) begin
      if (!in_ready) bad++;
      step();
    end
    in_valid = 1'b0;
    chk("wrap_rdy", 32'(bad), 32'd0);
    chk("wrap_254", 32'(out_count), 32'd254);
    step();
    chk("wrap_255", 32'(out_count), 32'd255);
    step();
    chk("wrap_zero", 32'(out_count), 32'd0);

    in_data  = vec(5'b00001);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("relat_v", 32'(out_valid), 32'd1);
    chk("relat_d", 32'(out_data), 32'h03);
    step();
    chk("relat_c", 32'(out_count), 32'd1);

    // Random stream with out_ready toggling every cycle
    acc_n     = 0;
    cyc       = 0;
    out_ready = 1'b0;
    while (acc_n < 1000 && cyc < 5000) begin
      out_ready = ~out_ready;
      in_data   = 15'($urandom_range(0, 32767));
      in_valid  = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_dup", 32'd1, 32'd0);
        else begin
          exp_d = q.pop_front();
          chk("sb_data", 32'(out_data), 32'(exp_d));
        end
      end
      if (in_ready) begin
        q.push_back(model(in_data));
        acc_n++;
      end
      step();
      cyc++;
    end
    chk("sb_budget", 32'(acc_n), 32'd1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) chk("sb_dup", 32'd1, 32'd0);
        else begin
          exp_d = q.pop_front();
          chk("sb_data", 32'(out_data), 32'(exp_d));
        end
      end
      step();
    end
    chk("sb_drop", 32'(q.size()), 32'd0);
    chk("sb_count", 32'(out_count), 32'd233);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
